soundweb_decoder: RTL



---
 rtl/soundweb_pkg.sv | 18 +
 rtl/soundweb_decoder_if.sv | 8 +
 rtl/soundweb_unstuff.sv | 46 ++++
 rtl/soundweb_decoder.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/soundweb_pkg.sv
// Soundweb London wire constants and framing state, shared by the encoder and decoder.
package soundweb_pkg;
  localparam logic [7:0] STX        = 8'h02;
  localparam logic [7:0] ETX        = 8'h03;
  localparam logic [7:0] ACK        = 8'h06;
  localparam logic [7:0] NAK        = 8'h15;
  localparam logic [7:0] ESC        = 8'h1B;
  localparam logic [7:0] ESC_OFFSET = 8'h80;
  localparam int         BODY_LEN   = 14;
  localparam int         FIELD_N    = 13;

  typedef enum logic [1:0] {IDLE, BODY, ESC_WAIT, DISCARD} sw_state_e;

  // Bytes that must never appear raw inside a frame body.
  function automatic logic is_special(input logic [7:0] b);
    return (b == STX) || (b == ETX) || (b == ACK) || (b == NAK) || (b == ESC);
  endfunction
endpackage

// File: rtl/soundweb_decoder_if.sv
// Receive byte stream into the decoder: one byte per cycle, no backpressure.
interface soundweb_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output rx_data, rx_valid);
  modport slave  (input  rx_data, rx_valid);
endinterface

// File: rtl/soundweb_unstuff.sv
// Byte classifier / unescaper: turns a wire byte into a body byte or a control strobe.
module soundweb_unstuff
  import soundweb_pkg::*;
(
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       esc_wait,
  output logic [7:0] body_byte,
  output logic       body_vld,
  output logic       stx,
  output logic       etx,
  output logic       esc,
  output logic       ack,
  output logic       nak,
  output logic       bad_esc
);
  always_comb begin
    body_byte = rx_data;
    body_vld  = 1'b0;
    stx       = 1'b0;
    etx       = 1'b0;
    esc       = 1'b0;
    ack       = 1'b0;
    nak       = 1'b0;
    bad_esc   = 1'b0;
    if (rx_valid) begin
      if (rx_data == STX) begin
        stx = 1'b1;
      end else if (esc_wait) begin
        // Only the five escaped codes are legal after ESC; anything else (ETX included) is an error.
        if (is_special(rx_data - ESC_OFFSET)) begin
          body_vld  = 1'b1;
          body_byte = rx_data - ESC_OFFSET;
        end else begin
          bad_esc = 1'b1;
        end
      end else begin
        etx      = (rx_data == ETX);
        esc      = (rx_data == ESC);
        ack      = (rx_data == ACK);
        nak      = (rx_data == NAK);
        body_vld = !(etx || esc);
      end
    end
  end
endmodule

// File: rtl/soundweb_decoder.sv
// Soundweb London frame decoder: deframes, unescapes, checks XOR and latches good frames.
module soundweb_decoder
  import soundweb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TIMEOUT_W      = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  soundweb_decoder_if.slave  rx,
  output logic [7:0]         command,
  output logic [7:0]         address_0,
  output logic [7:0]         address_1,
  output logic [7:0]         address_2,
  output logic [7:0]         address_3,
  output logic [7:0]         address_4,
  output logic [7:0]         address_5,
  output logic [7:0]         sv_0,
  output logic [7:0]         sv_1,
  output logic [7:0]         data_0,
  output logic [7:0]         data_1,
  output logic [7:0]         data_2,
  output logic [7:0]         data_3,
  output logic               msg_valid,
  output logic               ack_seen,
  output logic               nak_seen,
  output logic               err_checksum,
  output logic               err_length,
  output logic               err_framing
);
  localparam logic [TIMEOUT_W-1:0] GAP_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  sw_state_e                    state_q, state_d;
  logic [3:0]                   cnt_q, cnt_d;
  logic [7:0]                   xor_q, xor_d;
  logic [TIMEOUT_W-1:0]         gap_q, gap_d;
  logic [BODY_LEN-1:0][7:0]     shadow_q;
  logic [FIELD_N-1:0][7:0]      field_q;
  logic                         store, load;
  logic msg_d, ack_d, nak_d, cks_d, len_d, frm_d;

  logic [7:0] u_byte;
  logic       u_vld, u_stx, u_etx, u_esc, u_ack, u_nak, u_bad;

  soundweb_unstuff u_unstuff (
    .rx_valid (rx.rx_valid),
    .rx_data  (rx.rx_data),
    .esc_wait (state_q == ESC_WAIT),
    .body_byte(u_byte),
    .body_vld (u_vld),
    .stx      (u_stx),
    .etx      (u_etx),
    .esc      (u_esc),
    .ack      (u_ack),
    .nak      (u_nak),
    .bad_esc  (u_bad)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xor_d   = xor_q;
    gap_d   = gap_q;
    store   = 1'b0;
    load    = 1'b0;
    msg_d   = 1'b0;
    ack_d   = 1'b0;
    nak_d   = 1'b0;
    cks_d   = 1'b0;
    len_d   = 1'b0;
    frm_d   = 1'b0;
    if (state_q == IDLE) begin
      gap_d = '0;
      if (u_stx) begin
        state_d = BODY;
        cnt_d   = '0;
        xor_d   = '0;
      end else begin
        ack_d = u_ack;
        nak_d = u_nak;
      end
    end else if (!rx.rx_valid) begin
      gap_d = gap_q + 1'b1;
      if (gap_q == GAP_LAST) begin
        frm_d   = (state_q != DISCARD);
        state_d = IDLE;
        gap_d   = '0;
      end
    end else begin
      gap_d = '0;
      if (u_stx) begin
        frm_d   = (state_q != DISCARD);
        state_d = BODY;
        cnt_d   = '0;
        xor_d   = '0;
      end else if (state_q == DISCARD) begin
        if (u_etx) state_d = IDLE;
      end else if (u_bad) begin
        frm_d   = 1'b1;
        state_d = IDLE;
      end else if (u_esc) begin
        state_d = ESC_WAIT;
      end else if (u_etx) begin
        state_d = IDLE;
        if (cnt_q != 4'(BODY_LEN)) len_d = 1'b1;
        else if (xor_q != 8'h00)   cks_d = 1'b1;
        else begin
          msg_d = 1'b1;
          load  = 1'b1;
        end
      end else if (u_vld) begin
        if (cnt_q == 4'(BODY_LEN)) begin
          len_d   = 1'b1;
          state_d = DISCARD;
        end else begin
          store   = 1'b1;
          cnt_d   = cnt_q + 4'd1;
          xor_d   = xor_q ^ u_byte;
          state_d = BODY;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      xor_q        <= '0;
      gap_q        <= '0;
      shadow_q     <= '0;
      field_q      <= '0;
      msg_valid    <= 1'b0;
      ack_seen     <= 1'b0;
      nak_seen     <= 1'b0;
      err_checksum <= 1'b0;
      err_length   <= 1'b0;
      err_framing  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      xor_q        <= xor_d;
      gap_q        <= gap_d;
      if (store) shadow_q[cnt_q] <= u_byte;
      if (load)  field_q <= shadow_q[FIELD_N-1:0];
      msg_valid    <= msg_d;
      ack_seen     <= ack_d;
      nak_seen     <= nak_d;
      err_checksum <= cks_d;
      err_length   <= len_d;
      err_framing  <= frm_d;
    end
  end

  assign command   = field_q[0];
  assign address_0 = field_q[1];
  assign address_1 = field_q[2];
  assign address_2 = field_q[3];
  assign address_3 = field_q[4];
  assign address_4 = field_q[5];
  assign address_5 = field_q[6];
  assign sv_0      = field_q[7];
  assign sv_1      = field_q[8];
  assign data_0    = field_q[9];
  assign data_1    = field_q[10];
  assign data_2    = field_q[11];
  assign data_3    = field_q[12];
endmodule
